// File: rtl/bus_memory_ctrl.sv
// bus_memory_ctrl: RAM bus slave with its own MAR, a wait-state read handshake and one I/O port.
// Optional feature macro MEM_PARITY_EN: per-word even-parity bit with a sticky read error flag.
module bus_memory_ctrl #(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0,
   parameter int IO_ADDR     = 'hFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_bus,
   input  logic [DATA_W-1:0] bus_in,
   input  logic              c_mi,
   input  logic              c_ri,
   input  logic              c_ro,
   input  logic              inj_parity,
   input  logic [DATA_W-1:0] io_in,
   output logic [DATA_W-1:0] bus_out,
   output logic              bus_oe,
   output logic              ready,
   output logic [DATA_W-1:0] io_out,
   output logic              io_strobe,
   output logic              parity_err
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] WAIT  = 2'd1;
   localparam logic [1:0] VALID = 2'd2;

   localparam logic [ADDR_W-1:0] IO_A = ADDR_W'(IO_ADDR);
   localparam logic [3:0] WS_INIT =
      (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   logic [ADDR_W-1:0] mar;
   logic [1:0]        state;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] mem_q;
   logic [DATA_W-1:0] mem [DEPTH];

   logic              is_io;
   logic              is_ram;
   logic              load;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] load_data;

   // I/O decode wins over RAM; anything else beyond DEPTH is unmapped
   assign is_io  = (mar == IO_A);
   assign is_ram = !is_io && (32'(mar) < DEPTH);
   assign idx    = mar[IDX_W-1:0];

   assign load = c_ro &&
      ((state == IDLE && WAIT_STATES == 0) ||
       (state == WAIT && cnt == 4'd0));

   assign load_data = is_io  ? io_in :
                      is_ram ? mem[idx] : '0;

   assign bus_out = mem_q;
   assign ready   = (state == VALID);
   assign bus_oe  = ready && c_ro;

   always_ff @(posedge clk) begin
      if (reset) begin
         mar       <= '0;
         state     <= IDLE;
         cnt       <= '0;
         mem_q     <= '0;
         io_out    <= '0;
         io_strobe <= 1'b0;
      end else begin
         io_strobe <= c_ri && is_io;
         if (c_ri && is_io)
            io_out <= bus_in;
         if (c_mi)
            mar <= addr_bus;
         if (load)
            mem_q <= load_data;
         unique case (state)
            IDLE: begin
               if (c_ro) begin
                  state <= (WAIT_STATES == 0) ? VALID : WAIT;
                  cnt   <= WS_INIT;
               end
            end
            WAIT: begin
               if (!c_ro)
                  state <= IDLE;
               else if (cnt == 4'd0)
                  state <= VALID;
               else
                  cnt <= cnt - 4'd1;
            end
            VALID: begin
               if (!c_ro || c_mi || c_ri)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // RAM contents survive reset; writes use the pre-edge MAR
   always_ff @(posedge clk) begin
      if (!reset && c_ri && is_ram)
         mem[idx] <= bus_in;
   end

`ifdef MEM_PARITY_EN
   logic par [DEPTH];

   always_ff @(posedge clk) begin
      if (!reset && c_ri && is_ram)
         par[idx] <= ^bus_in ^ inj_parity;
   end

   always_ff @(posedge clk) begin
      if (reset)
         parity_err <= 1'b0;
      else if (load && is_ram && ((^mem[idx]) != par[idx]))
         parity_err <= 1'b1;
   end
`else
   logic unused_inj;
   assign unused_inj = inj_parity;
   assign parity_err = 1'b0;
`endif

endmodule
